// File: rtl/seq_match_logger.sv
// rtl/seq_match_logger.sv - match counter and timestamp event log for the "101" detector
//
// Samples the detector's match output every clock, keeps a saturating count of
// match events and logs a free-running cycle timestamp per event into a
// first-word-fall-through FIFO drained through rd_en.
//
// Optional build macro: SEQ_LOG_EDGE_EN
//   defined   - only a 0->1 transition of match_in is an event
//   undefined - every cycle with match_in=1 is an event
//
// Ports:
//   clk         rising-edge clock shared with the detector
//   rst_n       asynchronous active-low reset
//   clr         synchronous clear of all state, highest priority
//   match_in    detector output
//   rd_en       pop request, ignored while ts_valid=0
//   ts_out      timestamp at the FIFO head, 0 while empty
//   ts_valid    FIFO not empty
//   fifo_full   FIFO holds DEPTH entries
//   overflow    sticky, set when a push is dropped
//   match_count saturating count of accepted events

module seq_match_logger #(
  parameter int TS_W  = 16,
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             match_in,
  input  logic             rd_en,
  output logic [TS_W-1:0]  ts_out,
  output logic             ts_valid,
  output logic             fifo_full,
  output logic             overflow,
  output logic [CNT_W-1:0] match_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [TS_W-1:0]  TS_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [AW:0]      PTR_ONE = 1;

  logic [TS_W-1:0] ts_cnt;
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [TS_W-1:0] mem [DEPTH];

  logic ev;
  logic empty;
  logic full;
  logic pop;
  logic push_ok;
  logic drop;

`ifdef SEQ_LOG_EDGE_EN
  logic match_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_prev <= 1'b0;
    end else if (clr) begin
      match_prev <= 1'b0;
    end else begin
      match_prev <= match_in;
    end
  end

  assign ev = match_in & ~match_prev;
`else
  assign ev = match_in;
`endif

  // Pointers carry one extra wrap bit: equal => empty, only wrap bit differs => full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO still fits.
  assign pop     = rd_en & ~empty;
  assign push_ok = ev & (~full | pop);
  assign drop    = ev & full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow    <= 1'b0;
      match_count <= '0;
    end else if (clr) begin
      ts_cnt      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow    <= 1'b0;
      match_count <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_ONE;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (ev && (match_count != '1)) begin
        match_count <= match_count + CNT_ONE;
      end
    end
  end

  // Storage is not reset; only pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !clr) begin
      mem[wr_ptr[AW-1:0]] <= ts_cnt;
    end
  end

  assign ts_valid  = ~empty;
  assign fifo_full = full;
  assign ts_out    = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule
